// File: rtl/alu_mc.sv
// alu_mc: parameterised multi-cycle ALU for the MIPS datapath.
// Single-cycle ops (AND/OR/ADD/XOR/SUB/SLTU/SLT/NOR) complete one clock after
// start. MUL (shift-add), DIVU and REMU (restoring division) run WIDTH
// iterations under busy. All results and flags are registered and change
// only on a done cycle.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             operation request, sampled only while idle
//   alu_control[3:0]  opcode, captured with start
//   srcA, srcB        operands, captured with start
//   busy              multi-cycle operation in progress
//   done              one-cycle pulse, result/flags updated this cycle
//   alu_out           registered result
//   zero/carry/overflow/div_zero_flag  registered status flags
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             div_zero_flag
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                         OP_XOR = 4'b0011, OP_SUB  = 4'b0100, OP_MUL  = 4'b0101,
                         OP_SLTU= 4'b0110, OP_SLT  = 4'b0111, OP_DIVU = 4'b1000,
                         OP_REMU= 4'b1001, OP_NOR  = 4'b1010;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;    // MUL: multiplicand; DIV: dividend shifting into quotient
  logic [WIDTH-1:0] r_b;    // MUL: multiplier;   DIV: divisor
  logic [WIDTH-1:0] r_acc;  // MUL: product;      DIV: partial remainder
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_z, r_c, r_v, r_dz;

  logic w_multi, w_accept, w_last;
  assign w_multi  = (alu_control == OP_MUL) || (alu_control == OP_DIVU) ||
                    (alu_control == OP_REMU);
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && w_multi) w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == CW'(1))  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle datapath; ADD/SUB at WIDTH+1 bits so bit WIDTH is carry/borrow
  logic [WIDTH:0]   w_sum, w_dif;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_c, w_sc_v;
  assign w_sum = {1'b0, srcA} + {1'b0, srcB};
  assign w_dif = {1'b0, srcA} - {1'b0, srcB};

  always_comb begin
    w_sc_res = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    case (alu_control)
      OP_AND:  w_sc_res = srcA & srcB;
      OP_OR:   w_sc_res = srcA | srcB;
      OP_XOR:  w_sc_res = srcA ^ srcB;
      OP_NOR:  w_sc_res = ~(srcA | srcB);
      OP_ADD: begin
        w_sc_res = w_sum[WIDTH-1:0];
        w_sc_c   = w_sum[WIDTH];
        w_sc_v   = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (w_sum[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_dif[WIDTH-1:0];
        w_sc_c   = w_dif[WIDTH];
        w_sc_v   = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (w_dif[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_SLTU: w_sc_res = (srcA < srcB) ? '1 : '0;
      OP_SLT:  w_sc_res = ($signed(srcA) < $signed(srcB)) ? '1 : '0;
      default: w_sc_res = '0;
    endcase
  end

  // One iteration of shift-add multiply
  logic [WIDTH-1:0] w_mul_acc;
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

  // One iteration of restoring division: shift next dividend bit into the
  // remainder, subtract divisor, keep the difference if it did not borrow.
  // A zero divisor never borrows, giving quotient all-ones and remainder = srcA.
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
  assign w_shift   = {r_acc, r_a[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_b};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_a[WIDTH-2:0], w_ge};

  logic [WIDTH-1:0] w_mc_res;
  always_comb begin
    w_mc_res = '0;
    case (r_op)
      OP_MUL:  w_mc_res = w_mul_acc;
      OP_DIVU: w_mc_res = w_quo_nxt;
      OP_REMU: w_mc_res = w_rem_nxt;
      default: w_mc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= '0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_done <= 1'b0;
      r_out  <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept && !w_multi) begin
        r_out  <= w_sc_res;
        r_z    <= (w_sc_res == '0);
        r_c    <= w_sc_c;
        r_v    <= w_sc_v;
        r_dz   <= 1'b0;
        r_done <= 1'b1;
      end else if (w_accept) begin
        r_op  <= alu_control;
        r_cnt <= CW'(WIDTH);
        r_a   <= srcA;
        r_b   <= srcB;
        r_acc <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_op == OP_MUL) begin
          r_acc <= w_mul_acc;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
        end else begin
          r_acc <= w_rem_nxt;
          r_a   <= w_quo_nxt;
        end
        if (w_last) begin
          r_out  <= w_mc_res;
          r_z    <= (w_mc_res == '0);
          r_c    <= 1'b0;
          r_v    <= 1'b0;
          r_dz   <= (r_op != OP_MUL) && (r_b == '0);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy          = (r_state == S_RUN);
  assign done          = r_done;
  assign alu_out       = r_out;
  assign zero_flag     = r_z;
  assign carry_flag    = r_c;
  assign overflow_flag = r_v;
  assign div_zero_flag = r_dz;
endmodule
